// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch type codes, 2-bit counter states and the
// saturating counter step used by the branch history table.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BEQ     = 3'd1,
    BNE     = 3'd2,
    BLT     = 3'd3,
    BLTU    = 3'd4,
    BGE     = 3'd5,
    BGEU    = 3'd6
  } br_type_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating step toward ST on taken, toward SNT on not taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'b01;
      else           nxt = ST;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'b01;
      else            nxt = SNT;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ex_branch_resolve_if.sv
// Signal bundle between the pipeline (IF lookup side, ID/EX register) and
// the EX-stage branch resolver. master = pipeline side, slave = resolver.
interface ex_branch_resolve_if;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        en_e;
  logic [31:0] pc_e;
  logic [31:0] br_npc_e;
  logic [2:0]  br_type_e;
  logic        predicted_e;
  logic [31:0] op1_e;
  logic [31:0] op2_e;
  logic        taken_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  modport slave (
    input  pc_f, en_e, pc_e, br_npc_e, br_type_e, predicted_e, op1_e, op2_e,
    output pred_taken_f, pred_target_f, taken_e, mispredict_e, redirect_pc_e,
           branch_cnt, mispred_cnt
  );

  modport master (
    output pc_f, en_e, pc_e, br_npc_e, br_type_e, predicted_e, op1_e, op2_e,
    input  pred_taken_f, pred_target_f, taken_e, mispredict_e, redirect_pc_e,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/ex_branch_resolve_cond.sv
// Combinational branch condition evaluation over full 32-bit operands.
// Unknown codes and BR_NONE resolve as not taken.
module branch_cond_unit
  import cpu_pkg::*;
(
  input  logic [2:0]  br_type,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        taken
);

  // Select the comparison that matches the branch type.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BEQ:     taken = (op1 == op2);
      BNE:     taken = (op1 != op2);
      BLT:     taken = ($signed(op1) <  $signed(op2));
      BLTU:    taken = (op1 <  op2);
      BGE:     taken = ($signed(op1) >= $signed(op2));
      BGEU:    taken = (op1 >= op2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolver: evaluates the branch, flags mispredictions with
// a same-cycle redirect, owns the BTB / 2-bit BHT read by IF, and counts
// resolved and mispredicted branches.
module ex_branch_resolve
  import cpu_pkg::*;
#(
  parameter int          ENTRIES  = 64,
  localparam int         IDX_W    = $clog2(ENTRIES),
  parameter logic [1:0]  CTR_INIT = WT
) (
  input logic             clk,
  input logic             rst,
  ex_branch_resolve_if.slave bus
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [31:0]       target_r [ENTRIES];
  logic [1:0]        ctr_r    [ENTRIES];
  logic [31:0]       branch_cnt_r;
  logic [31:0]       mispred_cnt_r;

  logic [IDX_W-1:0]  idx_f_s;
  logic [IDX_W-1:0]  idx_e_s;
  logic [TAG_W-1:0]  tag_e_s;
  logic              hit_f_s;
  logic              hit_e_s;
  logic              is_br_s;
  logic              taken_s;
  logic              mispredict_s;
  logic              unused_pc_bits_s;

  assign idx_f_s = bus.pc_f[IDX_W+1:2];
  assign idx_e_s = bus.pc_e[IDX_W+1:2];
  assign tag_e_s = bus.pc_e[31:IDX_W+2];
  assign hit_f_s = valid_r[idx_f_s] && (tag_r[idx_f_s] == bus.pc_f[31:IDX_W+2]);
  assign hit_e_s = valid_r[idx_e_s] && (tag_r[idx_e_s] == tag_e_s);
  assign is_br_s = (bus.br_type_e != BR_NONE);
  assign unused_pc_bits_s = ^bus.pc_f[1:0];

  branch_cond_unit u_cond (
    .br_type (bus.br_type_e),
    .op1     (bus.op1_e),
    .op2     (bus.op2_e),
    .taken   (taken_s)
  );

  // Lookup and redirect outputs; the lookup sees pre-update table state.
  always_comb begin
    bus.pred_taken_f  = 1'b0;
    bus.pred_target_f = 32'h0000_0000;
    if (hit_f_s) begin
      bus.pred_taken_f  = ctr_r[idx_f_s][1];
      bus.pred_target_f = target_r[idx_f_s];
    end else begin
      bus.pred_taken_f  = 1'b0;
      bus.pred_target_f = 32'h0000_0000;
    end
    // A non-branch predicted taken is a stale alias and must be redirected.
    if (is_br_s) mispredict_s = (bus.predicted_e != taken_s);
    else         mispredict_s = bus.predicted_e;
    bus.taken_e       = taken_s;
    bus.mispredict_e  = mispredict_s;
    bus.redirect_pc_e = taken_s ? bus.br_npc_e : (bus.pc_e + 32'd4);
    bus.branch_cnt    = branch_cnt_r;
    bus.mispred_cnt   = mispred_cnt_r;
  end

  // Table and counter update, only when EX advances; reset clears all state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'h0000_0000;
        ctr_r[i]    <= SNT;
      end
      branch_cnt_r  <= 32'h0000_0000;
      mispred_cnt_r <= 32'h0000_0000;
    end else if (bus.en_e) begin
      if (is_br_s) begin
        if (hit_e_s) begin
          ctr_r[idx_e_s]    <= ctr_next(ctr_r[idx_e_s], taken_s);
          target_r[idx_e_s] <= bus.br_npc_e;
        end else if (taken_s) begin
          valid_r[idx_e_s]  <= 1'b1;
          tag_r[idx_e_s]    <= tag_e_s;
          target_r[idx_e_s] <= bus.br_npc_e;
          ctr_r[idx_e_s]    <= CTR_INIT;
        end
        branch_cnt_r <= branch_cnt_r + 32'd1;
      end
      mispred_cnt_r <= mispred_cnt_r + {31'd0, mispredict_s};
    end
  end

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Self-checking bench for ex_branch_resolve: directed steps followed by a
// randomized run, all compared against a table-level reference model.
module tb_ex_branch_resolve;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ex_branch_resolve_if bus ();

  ex_branch_resolve dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: 64 entries, index = (pc/4) mod 64, tag = pc/256.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic [31:0] m_brcnt;
  logic [31:0] m_miscnt;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 8));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[m_idx(pc)] : 32'd0;
  endfunction

  function automatic bit ref_taken(input int t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      1: return a == b;
      2: return a != b;
      3: return $signed(a) < $signed(b);
      4: return a < b;
      5: return $signed(a) >= $signed(b);
      6: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 0;
    end
    m_brcnt = 32'd0;
    m_miscnt = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lookup(input logic [31:0] pc);
    bus.pc_f = pc;
    #1;
    chk("pred_taken_f", {31'd0, bus.pred_taken_f}, {31'd0, m_pred(pc)});
    chk("pred_target_f", bus.pred_target_f, m_target(pc));
  endtask

  task automatic chk_counters();
    chk("branch_cnt", bus.branch_cnt, m_brcnt);
    chk("mispred_cnt", bus.mispred_cnt, m_miscnt);
  endtask

  // One EX cycle: drive just after a posedge, check mid-cycle, clock, update model.
  task automatic ex_cycle(input logic [31:0] pc, input logic [31:0] npc, input int t,
                          input bit pred, input logic [31:0] a, input logic [31:0] b,
                          input bit en, input logic [31:0] pcf);
    bit exp_taken, exp_mis, isbr;
    int ix;
    bus.pc_e = pc; bus.br_npc_e = npc; bus.br_type_e = 3'(t);
    bus.predicted_e = pred; bus.op1_e = a; bus.op2_e = b; bus.en_e = en;
    isbr = (t != 0);
    exp_taken = ref_taken(t, a, b);
    exp_mis = isbr ? (pred != exp_taken) : pred;
    chk_lookup(pcf);
    chk("taken_e", {31'd0, bus.taken_e}, {31'd0, exp_taken});
    chk("mispredict_e", {31'd0, bus.mispredict_e}, {31'd0, exp_mis});
    if (exp_mis) chk("redirect_pc_e", bus.redirect_pc_e, exp_taken ? npc : pc + 32'd4);
    chk_counters();
    @(posedge clk);
    if (en) begin
      ix = m_idx(pc);
      if (isbr) begin
        if (m_hit(pc)) begin
          m_ctr[ix] = exp_taken ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                                : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
          m_tgt[ix] = npc;
        end else if (exp_taken) begin
          m_valid[ix] = 1'b1; m_tag[ix] = pc >> 8; m_tgt[ix] = npc; m_ctr[ix] = 2;
        end
        m_brcnt = m_brcnt + 32'd1;
      end
      if (exp_mis) m_miscnt = m_miscnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle();
    bus.en_e = 1'b0; bus.br_type_e = 3'd0; bus.predicted_e = 1'b0;
  endtask

  logic [31:0] brc_before;
  logic [31:0] rpc, rpcf, ra, rb;
  int          rt;
  bit          rpred, ren;

  initial begin
    bus.pc_f = 32'd0; bus.pc_e = 32'd0; bus.br_npc_e = 32'd0; bus.br_type_e = 3'd0;
    bus.predicted_e = 1'b0; bus.op1_e = 32'd0; bus.op2_e = 32'd0; bus.en_e = 1'b0;
    m_reset();

    // 1: reset state
    #2;
    chk_lookup(32'h100);
    chk("rst_pred_taken", {31'd0, bus.pred_taken_f}, 32'd0);
    chk_counters();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 2: first BEQ taken, unpredicted -> allocate
    ex_cycle(32'h100, 32'h140, 1, 1'b0, 32'd5, 32'd5, 1'b1, 32'h100);
    idle();
    chk_lookup(32'h100);
    chk("beq_alloc_target", bus.pred_target_f, 32'h140);
    chk("beq_brcnt", bus.branch_cnt, 32'd1);
    chk("beq_miscnt", bus.mispred_cnt, 32'd1);

    // 3: not taken twice, then taken; pred follows the table
    ex_cycle(32'h100, 32'h140, 1, m_pred(32'h100), 32'd1, 32'd2, 1'b1, 32'h100);
    ex_cycle(32'h100, 32'h140, 1, m_pred(32'h100), 32'd1, 32'd2, 1'b1, 32'h100);
    chk("nt_twice_miscnt", bus.mispred_cnt, 32'd2);
    ex_cycle(32'h100, 32'h140, 1, m_pred(32'h100), 32'd3, 32'd3, 1'b1, 32'h100);
    idle();
    chk_lookup(32'h100);
    chk("ctr01_pred", {31'd0, bus.pred_taken_f}, 32'd0);

    // 4: signed vs unsigned comparisons, BNE equal
    ex_cycle(32'h400, 32'h480, 3, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h400);
    ex_cycle(32'h400, 32'h480, 4, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h400);
    ex_cycle(32'h400, 32'h480, 5, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h400);
    ex_cycle(32'h400, 32'h480, 6, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h400);
    bus.br_type_e = 3'd2; bus.predicted_e = 1'b1; bus.op1_e = 32'd9; bus.op2_e = 32'd9;
    bus.pc_e = 32'h404; #1;
    chk("bne_eq_taken", {31'd0, bus.taken_e}, 32'd0);
    chk("bne_eq_redirect", bus.redirect_pc_e, 32'h408);

    // 5: mispredicted branch stalled three cycles, then advances
    brc_before = m_brcnt;
    for (int i = 0; i < 4; i++) begin
      ex_cycle(32'h500, 32'h600, 2, 1'b0, 32'd1, 32'd2, (i == 3), 32'h500);
    end
    idle();
    chk("stall_brcnt_once", bus.branch_cnt, brc_before + 32'd1);
    chk_counters();
    chk_lookup(32'h500);

    // 6: alias replacement at index 0, stale-alias non-branch, mid-sequence reset
    ex_cycle(32'h200, 32'h280, 1, m_pred(32'h200), 32'd7, 32'd7, 1'b1, 32'h200);
    idle();
    chk_lookup(32'h100);
    chk("alias_old_miss", bus.pred_target_f, 32'd0);
    ex_cycle(32'h300, 32'h380, 0, 1'b1, 32'd0, 32'd0, 1'b1, 32'h200);
    idle();
    chk_lookup(32'h200);
    chk("nonbr_table_kept", bus.pred_target_f, 32'h280);
    bus.pc_e = 32'h200; bus.br_npc_e = 32'h2C0; bus.br_type_e = 3'd1;
    bus.op1_e = 32'd1; bus.op2_e = 32'd1; bus.predicted_e = 1'b0; bus.en_e = 1'b1;
    #2; rst = 1'b1; #1;
    m_reset();
    chk_lookup(32'h200);
    chk_counters();
    @(posedge clk); #1;
    chk_lookup(32'h200);
    chk_counters();
    idle();
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized run over a small PC pool so hits and aliases occur
    for (int n = 0; n < 400; n++) begin
      rpc  = {22'($urandom_range(0, 3)), 8'h00} | {24'd0, 6'($urandom_range(0, 7)), 2'b00};
      rpcf = {22'($urandom_range(0, 3)), 8'h00} | {24'd0, 6'($urandom_range(0, 7)), 2'b00};
      rt   = int'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = ($urandom_range(0, 9) < 3) ? ra : $urandom;
      rpred = ($urandom_range(0, 9) < 7) ? m_pred(rpc) : 1'($urandom);
      ren  = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 9) == 0) rpcf = rpc;
      ex_cycle(rpc, $urandom, rt, rpred, ra, rb, ren, rpcf);
    end
    idle();
    #1;
    chk_counters();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
